// File: rtl/timer_irq_controller_pkg.sv
// rtl/timer_irq_controller_pkg.sv - shared types and constants for the timer interrupt controller
package timer_irq_pkg;
   localparam int MAX_SOURCES = 8;

   localparam logic [1:0] ADDR_PENDING = 2'd0;
   localparam logic [1:0] ADDR_MASK    = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      REQ       = 2'd1,
      WAIT_DROP = 2'd2
   } irq_state_t;
endpackage

// File: rtl/timer_irq_controller_if.sv
// rtl/timer_irq_controller_if.sv - register bus and CPU interrupt handshake bundle
interface timer_irq_controller_if;
   logic        write;
   logic [1:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        irq_req;
   logic [2:0]  irq_id;
   logic        irq_ack;

   modport master (
      output write, addr, data_in, irq_ack,
      input  data_out, irq_req, irq_id
   );

   modport slave (
      input  write, addr, data_in, irq_ack,
      output data_out, irq_req, irq_id
   );
endinterface

// File: rtl/timer_irq_controller_prio_enc.sv
// rtl/timer_irq_controller_prio_enc.sv - lowest-index-first priority encoder
module irq_prio_enc #(
   parameter int NUM_SOURCES = 8
) (
   input  logic [NUM_SOURCES-1:0] vec,
   output logic [2:0]             idx,
   output logic                   valid
);
   // Scan from the top so the lowest set index is the last one written.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = 3'(i);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/timer_irq_controller.sv
// rtl/timer_irq_controller.sv - collects timer interrupt edges and presents them one at a time to the CPU
module timer_irq_controller
   import timer_irq_pkg::*;
#(
   parameter int NUM_SOURCES = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SOURCES-1:0] irq_in,
   timer_irq_controller_if.slave  bus
);
   logic [NUM_SOURCES-1:0] irq_prev;
   logic [NUM_SOURCES-1:0] pending;
   logic [NUM_SOURCES-1:0] mask;
   logic [NUM_SOURCES-1:0] overrun;
   logic [NUM_SOURCES-1:0] edge_det;
   logic [NUM_SOURCES-1:0] ack_clr;
   logic [NUM_SOURCES-1:0] pend_clr;
   logic [NUM_SOURCES-1:0] ovr_clr;
   logic [2:0]             irq_id_q;
   logic [2:0]             enc_idx;
   logic                   enc_valid;
   logic                   wr_pending;
   logic                   wr_mask;
   logic                   wr_status;
   logic                   ack_taken;
   logic [31:0]            status_word;
   irq_state_t             state;
   irq_state_t             state_next;

   assign edge_det   = irq_in & ~irq_prev;
   assign wr_pending = bus.write && (bus.addr == ADDR_PENDING);
   assign wr_mask    = bus.write && (bus.addr == ADDR_MASK);
   assign wr_status  = bus.write && (bus.addr == ADDR_STATUS);
   assign ack_taken  = (state == REQ) && bus.irq_ack;

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         ack_clr[i] = ack_taken && (irq_id_q == 3'(i));
      end
   end

   assign pend_clr = (wr_pending ? bus.data_in[NUM_SOURCES-1:0] : '0) | ack_clr;
   assign ovr_clr  = wr_status ? bus.data_in[8 +: NUM_SOURCES] : '0;

   irq_prio_enc #(
      .NUM_SOURCES(NUM_SOURCES)
   ) u_prio_enc (
      .vec  (pending & mask),
      .idx  (enc_idx),
      .valid(enc_valid)
   );

   // Edges are OR-ed in after the clears so a new event always survives a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_prev <= '0;
         pending  <= '0;
         mask     <= '0;
         overrun  <= '0;
         irq_id_q <= '0;
         state    <= IDLE;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~pend_clr) | edge_det;
         overrun  <= (overrun & ~ovr_clr) | (edge_det & pending);
         if (wr_mask) begin
            mask <= bus.data_in[NUM_SOURCES-1:0];
         end
         if ((state == IDLE) && enc_valid) begin
            irq_id_q <= enc_idx;
         end
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (enc_valid)    state_next = REQ;
         REQ:       if (bus.irq_ack)  state_next = WAIT_DROP;
         WAIT_DROP: if (!bus.irq_ack) state_next = IDLE;
         default:                     state_next = IDLE;
      endcase
   end

   assign bus.irq_req = (state == REQ);
   assign bus.irq_id  = irq_id_q;

   assign status_word = {16'b0, MAX_SOURCES'(overrun), bus.irq_req, state, 2'b00, irq_id_q};

   always_comb begin
      bus.data_out = '0;
      case (bus.addr)
         ADDR_PENDING: bus.data_out = 32'(pending);
         ADDR_MASK:    bus.data_out = 32'(mask);
         ADDR_STATUS:  bus.data_out = status_word;
         default:      bus.data_out = '0;
      endcase
   end
endmodule

// File: tb/tb_timer_irq_controller.sv
// tb/tb_timer_irq_controller.sv - self-checking bench for timer_irq_controller
module tb_timer_irq_controller;
   import timer_irq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_in;
   int         errors = 0;
   int         checks = 0;

   timer_irq_controller_if bus();

   timer_irq_controller #(
      .NUM_SOURCES(8)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .irq_in(irq_in),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [7:0]  irq;
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic        ack;
      logic [1:0]  chk_addr;
      logic [31:0] exp_data;
      logic        exp_req;
      logic [2:0]  exp_id;
   } vec_t;

   vec_t tbl[21];

   // reference model state
   logic [7:0] m_pend, m_mask, m_ovr, m_prev;
   logic [2:0] m_id;
   irq_state_t m_st;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [7:0] irq, input logic w, input logic [1:0] a,
                        input logic [31:0] d, input logic ack);
      rst         = r;
      irq_in      = irq;
      bus.write   = w;
      bus.addr    = a;
      bus.data_in = d;
      bus.irq_ack = ack;
      @(posedge clk);
      #1;
      bus.write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      bus.addr = a;
      #1;
      v = bus.data_out;
   endtask

   task automatic wait_req(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.irq_req) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_step(input logic r, input logic [7:0] irq, input logic w, input logic [1:0] a,
                             input logic [31:0] d, input logic ack);
      logic [7:0] rise, clr, oclr, ready;
      int first;
      if (r) begin
         m_pend = '0; m_mask = '0; m_ovr = '0; m_prev = '0; m_id = '0; m_st = IDLE;
         return;
      end
      rise  = irq & ~m_prev;
      clr   = (w && a == ADDR_PENDING) ? d[7:0] : 8'h00;
      oclr  = (w && a == ADDR_STATUS) ? d[15:8] : 8'h00;
      ready = m_pend & m_mask;
      first = -1;
      for (int i = 0; i < 8; i++) if (first < 0 && ready[i]) first = i;
      if (m_st == IDLE) begin
         if (first >= 0) begin
            m_st = REQ;
            m_id = 3'(first);
         end
      end else if (m_st == REQ) begin
         if (ack) begin
            clr[m_id] = 1'b1;
            m_st = WAIT_DROP;
         end
      end else if (!ack) begin
         m_st = IDLE;
      end
      m_ovr  = (m_ovr & ~oclr) | (rise & m_pend);
      m_pend = (m_pend & ~clr) | rise;
      if (w && a == ADDR_MASK) m_mask = d[7:0];
      m_prev = irq;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] a);
      case (a)
         ADDR_PENDING: return {24'b0, m_pend};
         ADDR_MASK:    return {24'b0, m_mask};
         ADDR_STATUS:  return {16'b0, m_ovr, (m_st == REQ), 2'(m_st), 2'b00, m_id};
         default:      return 32'h0;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic        ok;
      int          tcnt[8];
      logic [7:0]  tv;
      logic        ack;
      int          served[8];
      int          order[$];
      logic        r, w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [7:0]  irq;

      rst = 1'b1; irq_in = '0;
      bus.write = 1'b0; bus.addr = '0; bus.data_in = '0; bus.irq_ack = 1'b0;

      //           rst irq    w  a     d               ack chk   exp             req id
      tbl[0]  = '{1'b1, 8'h00, 0, 2'd0, 32'h0,         0, 2'd0, 32'h0000_0000, 0, 3'd0};
      tbl[1]  = '{1'b0, 8'h00, 1, 2'd1, 32'hFF,        0, 2'd1, 32'h0000_00FF, 0, 3'd0};
      tbl[2]  = '{1'b0, 8'h20, 0, 2'd0, 32'h0,         0, 2'd0, 32'h0000_0020, 0, 3'd0};
      tbl[3]  = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         0, 2'd0, 32'h0000_0020, 1, 3'd5};
      tbl[4]  = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         1, 2'd0, 32'h0000_0000, 0, 3'd5};
      tbl[5]  = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         0, 2'd2, 32'h0000_0005, 0, 3'd5};
      tbl[6]  = '{1'b0, 8'h00, 1, 2'd1, 32'h0,         0, 2'd1, 32'h0000_0000, 0, 3'd5};
      tbl[7]  = '{1'b0, 8'h08, 0, 2'd0, 32'h0,         0, 2'd0, 32'h0000_0008, 0, 3'd5};
      tbl[8]  = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         0, 2'd0, 32'h0000_0008, 0, 3'd5};
      tbl[9]  = '{1'b0, 8'h00, 1, 2'd1, 32'h08,        0, 2'd1, 32'h0000_0008, 0, 3'd5};
      tbl[10] = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         0, 2'd2, 32'h0000_00A3, 1, 3'd3};
      tbl[11] = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         1, 2'd2, 32'h0000_0043, 0, 3'd3};
      tbl[12] = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         0, 2'd0, 32'h0000_0000, 0, 3'd3};
      tbl[13] = '{1'b0, 8'h00, 1, 2'd1, 32'h0,         0, 2'd1, 32'h0000_0000, 0, 3'd3};
      tbl[14] = '{1'b0, 8'h02, 0, 2'd0, 32'h0,         0, 2'd0, 32'h0000_0002, 0, 3'd3};
      tbl[15] = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         0, 2'd2, 32'h0000_0003, 0, 3'd3};
      tbl[16] = '{1'b0, 8'h02, 0, 2'd0, 32'h0,         0, 2'd2, 32'h0000_0203, 0, 3'd3};
      tbl[17] = '{1'b0, 8'h00, 1, 2'd2, 32'h200,       0, 2'd2, 32'h0000_0003, 0, 3'd3};
      tbl[18] = '{1'b0, 8'h00, 1, 2'd0, 32'hFF,        0, 2'd0, 32'h0000_0000, 0, 3'd3};
      tbl[19] = '{1'b0, 8'h00, 1, 2'd3, 32'hFFFF_FFFF, 0, 2'd3, 32'h0000_0000, 0, 3'd3};
      tbl[20] = '{1'b0, 8'h00, 0, 2'd0, 32'h0,         0, 2'd1, 32'h0000_0000, 0, 3'd3};

      for (int k = 0; k < 21; k++) begin
         drive(tbl[k].rst, tbl[k].irq, tbl[k].w, tbl[k].a, tbl[k].d, tbl[k].ack);
         rd(tbl[k].chk_addr, v);
         check($sformatf("vec%0d_data", k), v, tbl[k].exp_data);
         check($sformatf("vec%0d_req", k), 32'(bus.irq_req), 32'(tbl[k].exp_req));
         check($sformatf("vec%0d_id", k), 32'(bus.irq_id), 32'(tbl[k].exp_id));
      end

      // two simultaneous edges are served lowest index first
      drive(1, 8'h00, 0, 2'd0, 32'h0, 0);
      drive(0, 8'h00, 1, ADDR_MASK, 32'hFF, 0);
      drive(0, 8'h44, 0, 2'd0, 32'h0, 0);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 0);
      wait_req(10, ok);
      check("pair_first_req", 32'(ok), 32'd1);
      check("pair_first_id", 32'(bus.irq_id), 32'd2);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 1);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 0);
      wait_req(10, ok);
      check("pair_second_req", 32'(ok), 32'd1);
      check("pair_second_id", 32'(bus.irq_id), 32'd6);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 1);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 0);
      rd(ADDR_PENDING, v);
      check("pair_pending_empty", v, 32'h0);

      // new edge in the same cycle as the ack that clears it
      drive(1, 8'h00, 0, 2'd0, 32'h0, 0);
      drive(0, 8'h00, 1, ADDR_MASK, 32'hFF, 0);
      drive(0, 8'h10, 0, 2'd0, 32'h0, 0);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 0);
      wait_req(10, ok);
      check("race_req", 32'(ok), 32'd1);
      check("race_id", 32'(bus.irq_id), 32'd4);
      drive(0, 8'h10, 0, 2'd0, 32'h0, 1);
      rd(ADDR_PENDING, v);
      check("race_set_wins", v, 32'h10);
      rd(ADDR_STATUS, v);
      check("race_status", v, 32'h0000_1044);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 0);
      wait_req(10, ok);
      check("race_rereq", 32'(ok), 32'd1);
      check("race_reid", 32'(bus.irq_id), 32'd4);

      // register clears while requesting do not withdraw the request
      drive(0, 8'h00, 1, ADDR_MASK, 32'h0, 0);
      check("hold_after_mask_clr", 32'(bus.irq_req), 32'd1);
      drive(0, 8'h00, 1, ADDR_PENDING, 32'hFF, 0);
      check("hold_after_pend_clr", 32'(bus.irq_req), 32'd1);
      check("hold_id", 32'(bus.irq_id), 32'd4);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 1);
      check("hold_ack_drops", 32'(bus.irq_req), 32'd0);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 0);
      drive(0, 8'h00, 0, 2'd0, 32'h0, 0);
      check("hold_no_rereq", 32'(bus.irq_req), 32'd0);

      // ack held while idle is ignored
      drive(0, 8'h00, 1, ADDR_MASK, 32'hFF, 1);
      drive(0, 8'h01, 0, 2'd0, 32'h0, 1);
      drive(0, 8'h01, 0, 2'd0, 32'h0, 1);
      check("idle_ack_req", 32'(bus.irq_req), 32'd1);
      check("idle_ack_id", 32'(bus.irq_id), 32'd0);
      drive(0, 8'h01, 0, 2'd0, 32'h0, 1);
      drive(0, 8'h80, 0, 2'd0, 32'h0, 0);
      drive(0, 8'h80, 0, 2'd0, 32'h0, 0);
      check("midreset_req_before", 32'(bus.irq_req), 32'd1);

      // reset mid-handshake with an input already high
      drive(1, 8'h80, 0, 2'd0, 32'h0, 0);
      check("midreset_req_dropped", 32'(bus.irq_req), 32'd0);
      rd(ADDR_PENDING, v);
      check("midreset_pending_clr", v, 32'h0);
      drive(0, 8'h80, 0, 2'd0, 32'h0, 0);
      rd(ADDR_PENDING, v);
      check("postreset_high_edge", v, 32'h80);

      // eight one-shot timers with reload values 10..17
      drive(1, 8'h00, 0, 2'd0, 32'h0, 0);
      drive(0, 8'h00, 1, ADDR_MASK, 32'hFF, 0);
      for (int i = 0; i < 8; i++) begin
         tcnt[i]   = 10 + i;
         served[i] = 0;
      end
      ack = 1'b0;
      for (int c = 0; c < 150; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (tcnt[i] > 0) tcnt[i]--;
            tv[i] = (tcnt[i] == 0);
         end
         if (bus.irq_req && !ack) begin
            served[bus.irq_id]++;
            order.push_back(int'(bus.irq_id));
            ack = 1'b1;
         end else begin
            ack = 1'b0;
         end
         drive(0, tv, 0, 2'd0, 32'h0, ack);
      end
      check("timer_services", 32'(order.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("timer%0d_once", i), 32'(served[i]), 32'd1);
         if (i < order.size()) check($sformatf("timer_order%0d", i), 32'(order[i]), 32'(i));
      end

      // randomized traffic against the reference model
      drive(1, 8'h00, 0, 2'd0, 32'h0, 0);
      model_step(1, 8'h00, 0, 2'd0, 32'h0, 0);
      irq = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         check("rnd_req", 32'(bus.irq_req), 32'(m_st == REQ));
         check("rnd_id", 32'(bus.irq_id), 32'(m_id));
         r   = ($urandom_range(0, 99) == 0);
         irq = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         w   = ($urandom_range(0, 3) == 0);
         a   = 2'($urandom);
         d   = $urandom;
         ack = ($urandom_range(0, 1) == 1);
         rst = r; irq_in = irq;
         bus.write = w; bus.addr = a; bus.data_in = d; bus.irq_ack = ack;
         #1;
         check("rnd_data", bus.data_out, model_read(a));
         @(posedge clk);
         model_step(r, irq, w, a, d, ack);
         #1;
         bus.write = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
